// File: rtl/cdu_pkg.sv
// Shared types and constants for the CDU error-counter channel.
package cdu_pkg;

    // Default counter / DAC code width and saturation magnitude.
    localparam int CDU_CODE_WIDTH        = 10;
    localparam int ERR_CNT_LIMIT_DEFAULT = 384;

    // AGCEEC level that enables counting (ground-closure: low = enabled).
    localparam logic EEC_ACTIVE = 1'b0;

    // Signed counter / DAC code at the default width.
    typedef logic signed [CDU_CODE_WIDTH-1:0] cdu_code_t;

    // Per-channel pulse qualification states.
    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        HELD
    } pulse_state_t;

endpackage

// File: rtl/cdu_pulse_qualifier.sv
// Synchronises one asynchronous AGC command pulse, filters it with a
// saturating run counter and emits a single qualify strobe per pulse.
module cdu_pulse_qualifier
    import cdu_pkg::*;
#(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_async,
    output logic qualify
);

    localparam int RUN_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_CYCLES);

    logic [1:0]       sync_q;
    logic             pulse_sync;
    logic [RUN_W-1:0] run_q;
    pulse_state_t     state_q;
    pulse_state_t     state_d;

    assign pulse_sync = sync_q[1];

    // Two-flop synchroniser for the asynchronous pulse input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pulse_async};
        end
    end

    // Run counter: consecutive synchronised-high cycles, saturating at FILT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else if (!pulse_sync) begin
            run_q <= '0;
        end else if (run_q != RUN_MAX) begin
            run_q <= run_q + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: HELD blocks re-qualification until the input drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pulse_sync) state_d = ARMING;
            end
            ARMING: begin
                if (run_q == RUN_MAX) state_d = pulse_sync ? HELD : IDLE;
                else if (!pulse_sync) state_d = IDLE;
            end
            HELD: begin
                if (!pulse_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: qualify once, in the cycle the run count reaches FILT_CYCLES.
    always_comb begin
        qualify = (state_q == ARMING) && (run_q == RUN_MAX);
    end

endmodule

// File: rtl/cdu_error_counter.sv
// CDU error-counter front end: qualifies AGC up/down pulses and keeps a
// signed saturating count presented as a registered DAC code.
module cdu_error_counter
    import cdu_pkg::*;
#(
    parameter int WIDTH       = CDU_CODE_WIDTH,
    parameter int LIMIT       = ERR_CNT_LIMIT_DEFAULT,
    parameter int FILT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             AFpPCH,
    input  logic             AFmPCH,
    input  logic             AGCEEC,
    output logic [WIDTH-1:0] dac_code,
    output logic             dac_update,
    output logic             at_limit,
    output logic             cnt_zero,
    output logic             drop_pulse
);

    localparam logic signed [WIDTH-1:0] POS_LIM = WIDTH'(LIMIT);
    localparam logic signed [WIDTH-1:0] NEG_LIM = -POS_LIM;
    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1);

    logic                    up_qual;
    logic                    dn_qual;
    logic [1:0]              eec_sync_q;
    logic                    enabled;
    logic signed [WIDTH-1:0] count_q;
    logic signed [WIDTH-1:0] count_d;
    logic                    update_d;
    logic                    drop_d;

    cdu_pulse_qualifier #(
        .FILT_CYCLES(FILT_CYCLES)
    ) u_up_qual (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulse_async(AFpPCH),
        .qualify    (up_qual)
    );

    cdu_pulse_qualifier #(
        .FILT_CYCLES(FILT_CYCLES)
    ) u_dn_qual (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulse_async(AFmPCH),
        .qualify    (dn_qual)
    );

    assign enabled = (eec_sync_q[1] == EEC_ACTIVE);

    // Two-flop synchroniser for the enable discrete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eec_sync_q <= '0;
        end else begin
            eec_sync_q <= {eec_sync_q[0], AGCEEC};
        end
    end

    // Next count: limit check happens before the add, so the code never wraps.
    always_comb begin
        count_d  = count_q;
        update_d = 1'b0;
        drop_d   = 1'b0;
        if (!enabled) begin
            count_d  = '0;
            update_d = (count_q != '0);
        end else if (up_qual && !dn_qual) begin
            if (count_q == POS_LIM) begin
                drop_d = 1'b1;
            end else begin
                count_d  = count_q + ONE;
                update_d = 1'b1;
            end
        end else if (dn_qual && !up_qual) begin
            if (count_q == NEG_LIM) begin
                drop_d = 1'b1;
            end else begin
                count_d  = count_q - ONE;
                update_d = 1'b1;
            end
        end
    end

    // Count register with strobes aligned to the cycle the new code appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            dac_update <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            count_q    <= count_d;
            dac_update <= update_d;
            drop_pulse <= drop_d;
        end
    end

    // Flag decodes straight off the count register.
    always_comb begin
        dac_code = count_q;
        at_limit = (count_q == POS_LIM) || (count_q == NEG_LIM);
        cnt_zero = (count_q == '0);
    end

endmodule

// File: tb/tb_cdu_error_counter.sv
// Scoreboard bench for cdu_error_counter: stimulus pushes expected strobe
// events, a negedge monitor pops and compares them when the DUT strobes.
module tb_cdu_error_counter;
    import cdu_pkg::*;

    localparam int FILT = 4;
    localparam int LIM  = 384;
    localparam int HI   = 8;   // normal pulse width in clk cycles
    localparam int LO   = 6;   // gap after each pulse in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       AFpPCH = 1'b0;
    logic       AFmPCH = 1'b0;
    logic       AGCEEC = 1'b0;
    logic [9:0] dac_code;
    logic       dac_update;
    logic       at_limit;
    logic       cnt_zero;
    logic       drop_pulse;

    typedef struct {
        bit     is_drop;
        int     code;
        longint cyc;     // expected monitor cycle, -1 = not checked
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    int     n_upd  = 0;
    int     n_drop = 0;
    longint cyc    = 0;
    int     m_cnt  = 0;
    bit     m_en   = 1'b1;
    cdu_code_t got;

    cdu_error_counter #(
        .WIDTH      (10),
        .LIMIT      (LIM),
        .FILT_CYCLES(FILT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .AFpPCH    (AFpPCH),
        .AFmPCH    (AFmPCH),
        .AGCEEC    (AGCEEC),
        .dac_code  (dac_code),
        .dac_update(dac_update),
        .at_limit  (at_limit),
        .cnt_zero  (cnt_zero),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit lim_of(input int c);
        return (c == LIM) || (c == -LIM);
    endfunction

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (dac_update || drop_pulse)) begin
            got = dac_code;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: actual update=%0b drop=%0b code=%0d required no strobe",
                         dac_update, drop_pulse, int'(got));
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_drop", longint'(drop_pulse), longint'(mon_e.is_drop));
                chk("strobe_update", longint'(dac_update), longint'(!mon_e.is_drop));
                chk("strobe_code", longint'(int'(got)), longint'(mon_e.code));
                chk("strobe_at_limit", longint'(at_limit), longint'(lim_of(mon_e.code)));
                chk("strobe_cnt_zero", longint'(cnt_zero), longint'(mon_e.code == 0));
                if (mon_e.cyc >= 0) chk("strobe_latency", cyc, mon_e.cyc);
            end
            if (dac_update) n_upd++;
            if (drop_pulse) n_drop++;
        end
    end

    // Drive one pulse pair and push what the channel must do with it.
    task automatic do_pulse(input bit up, input bit dn, input int hi, input int lo);
        exp_t e;
        int   step;
        @(negedge clk);
        AFpPCH = up;
        AFmPCH = dn;
        step = int'(up) - int'(dn);
        if (hi >= FILT && m_en && step != 0) begin
            e.cyc = cyc + FILT + 3;
            if ((step == 1 && m_cnt == LIM) || (step == -1 && m_cnt == -LIM)) begin
                e.is_drop = 1'b1;
            end else begin
                m_cnt = m_cnt + step;
                e.is_drop = 1'b0;
            end
            e.code = m_cnt;
            sb.push_back(e);
        end
        repeat (hi) @(negedge clk);
        AFpPCH = 1'b0;
        AFmPCH = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic chk_code(input string name, input int req);
        got = dac_code;
        chk(name, longint'(int'(got)), longint'(req));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   d0;

        // Reset values, during and after reset.
        #3;
        chk_code("reset_code", 0);
        chk("reset_cnt_zero", longint'(cnt_zero), 1);
        chk("reset_update", longint'(dac_update), 0);
        chk("reset_drop", longint'(drop_pulse), 0);
        chk("reset_at_limit", longint'(at_limit), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_code("post_reset_code", 0);
        chk("post_reset_cnt_zero", longint'(cnt_zero), 1);

        // Basic up-count with latency checks.
        for (int i = 0; i < 10; i++) do_pulse(1'b1, 1'b0, HI, LO);
        chk_code("basic_code", 10);
        chk("basic_updates", longint'(n_upd), 10);

        // Short glitch must not count.
        do_pulse(1'b1, 1'b0, FILT - 1, LO);
        chk_code("glitch_code", 10);

        // Down to 5, then simultaneous up/down is a no-op.
        for (int i = 0; i < 5; i++) do_pulse(1'b0, 1'b1, HI, LO);
        do_pulse(1'b1, 1'b1, HI, LO);
        chk_code("simul_code", 5);

        // Down to -37, then disable.
        for (int i = 0; i < 42; i++) do_pulse(1'b0, 1'b1, HI, LO);
        chk_code("neg37_code", -37);
        @(negedge clk);
        AGCEEC = 1'b1;
        e.is_drop = 1'b0;
        e.code = 0;
        e.cyc = cyc + 3;
        sb.push_back(e);
        m_cnt = 0;
        m_en = 1'b0;
        d0 = n_upd;
        repeat (3) @(negedge clk);
        chk_code("disable_code", 0);
        do_pulse(1'b0, 1'b1, HI, LO);
        chk_code("disabled_ignore_code", 0);
        chk("disable_updates", longint'(n_upd - d0), 1);
        AGCEEC = 1'b0;
        repeat (4) @(negedge clk);
        m_en = 1'b1;
        do_pulse(1'b0, 1'b1, HI, LO);
        chk_code("reenable_code", -1);

        // Saturation from zero.
        do_pulse(1'b1, 1'b0, HI, LO);
        d0 = n_drop;
        for (int i = 0; i < 390; i++) do_pulse(1'b1, 1'b0, HI, LO);
        chk_code("sat_code", 384);
        chk("sat_at_limit", longint'(at_limit), 1);
        chk("sat_drops", longint'(n_drop - d0), 6);
        do_pulse(1'b0, 1'b1, HI, LO);
        chk_code("unsat_code", 383);
        chk("unsat_at_limit", longint'(at_limit), 0);

        // Async reset while count=200 and an up pulse is high.
        for (int i = 0; i < 183; i++) do_pulse(1'b0, 1'b1, HI, LO);
        chk_code("pre_reset_code", 200);
        chk("pre_reset_sb_empty", longint'(sb.size()), 0);
        @(negedge clk);
        AFpPCH = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_code("midreset_code", 0);
        chk("midreset_cnt_zero", longint'(cnt_zero), 1);
        chk("midreset_at_limit", longint'(at_limit), 0);
        chk("midreset_update", longint'(dac_update), 0);
        chk("midreset_drop", longint'(drop_pulse), 0);
        m_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 1;
        e.is_drop = 1'b0;
        e.code = 1;
        e.cyc = -1;
        sb.push_back(e);
        repeat (FILT + 4) @(negedge clk);
        AFpPCH = 1'b0;
        repeat (10) @(negedge clk);
        chk_code("after_reset_code", 1);
        chk("final_sb_empty", longint'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdu_error_counter.md
Name: cdu_error_counter

Overview:
- Digital front end of the CDU error-counter/DAC channel.
- Accepts the AGC's asynchronous increment (AFpPCH) and decrement (AFmPCH) command pulses, synchronises and glitch-filters them, and accumulates a signed saturating count.
- Presents the count as a registered signed DAC code, consumed by the analog ADACH/ACAEHI DAC model downstream.
- Counting is enabled by the AGC error-counter-enable discrete AGCEEC. When disabled, the counter is held at zero.

Parameters:
- WIDTH, 10, counter/DAC code width in bits, two's complement.
- LIMIT, 384, saturation magnitude; the count is clamped to [-LIMIT, +LIMIT]. Requires LIMIT <= 2^(WIDTH-1)-1.
- FILT_CYCLES, 4, number of consecutive synchronised-high clk cycles required to qualify a pulse (min 1).

Ports:
- clk  in  1  system clock; all logic synchronous to its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- AFpPCH  in  1  AGC increment pulse, asynchronous, nominal 2.5 us high.
- AFmPCH  in  1  AGC decrement pulse, asynchronous, nominal 2.5 us high.
- AGCEEC  in  1  error-counter enable discrete, asynchronous; 0 = enabled, 1 = disabled (ground-closure convention).
- dac_code  out  WIDTH  registered signed count, fed to the DAC.
- dac_update  out  1  one-cycle strobe in the cycle dac_code takes a new value.
- at_limit  out  1  high while |dac_code| == LIMIT.
- cnt_zero  out  1  high while dac_code == 0.
- drop_pulse  out  1  one-cycle strobe when a qualified pulse is discarded.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchronisers, filters and the counter clear to 0.
  - Outputs during reset: dac_code=0, dac_update=0, at_limit=0, cnt_zero=1, drop_pulse=0.
- Synchronisation: AFpPCH, AFmPCH and AGCEEC each pass through a 2-flop synchroniser.
- Filter (per pulse input): a saturating run counter counts consecutive synchronised-high cycles and clears on any low cycle.
  - A qualify event fires exactly once per pulse, in the cycle the run count reaches FILT_CYCLES.
  - The input must return low for at least 1 synchronised cycle before the next qualify event can fire.
  - Pulses shorter than FILT_CYCLES cycles are ignored.
- Per-channel FSM: IDLE -> ARMING (input high, run < FILT_CYCLES) -> HELD (qualified, waiting for low) -> IDLE.
  - ARMING -> IDLE on any low cycle.
- Count update, evaluated in the same cycle as the qualify events; registered, so dac_code changes 1 cycle after the qualify event.
  - Nominal latency: input rising edge to dac_code change = 2 (sync) + FILT_CYCLES + 1 cycles.
  - Net step = (+1 if up qualified) + (-1 if down qualified).
  - Both qualified in the same cycle: net 0, no change, no dac_update, no drop_pulse.
  - Up at +LIMIT, or down at -LIMIT: count holds, dac_update=0, drop_pulse=1 for 1 cycle.
  - Otherwise count += step and dac_update=1 for 1 cycle.
- Enable: while synchronised AGCEEC=1, the counter is forced to 0.
  - Qualify events are consumed without effect; drop_pulse stays 0 in this case.
  - If the count was non-zero on the first disabled cycle, dac_update pulses once as it clears.
  - On the AGCEEC 1->0 transition, counting resumes from 0 with the next qualify event.
  - A pulse already in ARMING still completes and counts if enable is asserted by its qualify cycle.
- Flags are combinational decodes of the dac_code register, so they track it with no additional latency.
- Reset mid-pulse: a pulse still high when rst_n deasserts must rise through synchronisation afresh.
  - It counts once if it remains high for FILT_CYCLES more synchronised cycles.
- Arithmetic: WIDTH-bit signed. The saturation check precedes the add, so no wrap-around is ever possible.

Decomposition:
- Shared package cdu_pkg holds:
  - the counter code type (signed [WIDTH-1:0]);
  - ERR_CNT_LIMIT_DEFAULT = 384 and the enable-polarity constant EEC_ACTIVE = 1'b0;
  - the pulse-FSM state enum (IDLE, ARMING, HELD).
- One sub-module, cdu_pulse_qualifier, combines the 2-flop sync, run counter and FSM, and emits the qualify strobe. It is instantiated twice (up/down).
- The AGCEEC synchroniser and the counter/saturation logic live in the top module.

Test Plan:
- Reset value: hold rst_n=0, then release. Required: dac_code=0, cnt_zero=1, and all strobes 0.
- Basic up-count: AGCEEC=0, apply 10 AFpPCH pulses each 2.5 us wide, every 310 us. Required: dac_code=10, exactly 10 dac_update strobes, each lagging its rising edge by 2+FILT_CYCLES+1 clk.
- Saturation: enable, then apply 390 AFpPCH pulses. Required: dac_code=384, at_limit=1, drop_pulse seen 6 times. Then 1 AFmPCH pulse gives dac_code=383 and at_limit=0.
- Glitch and simultaneous: a (FILT_CYCLES-1)-cycle AFpPCH glitch gives no change. AFpPCH and AFmPCH rising in the same cycle from count 5 give count stays 5, with no dac_update and no drop_pulse.
- Disable: with count=-37, set AGCEEC=1. Required: dac_code=0 within 3 cycles with 1 dac_update, and a subsequent AFmPCH pulse is ignored. Then set AGCEEC=0 and apply 1 AFmPCH pulse. Required: dac_code=-1.
- Async reset mid-count: assert rst_n=0 while count=200 and AFpPCH is high. Required: outputs are immediately at reset values. After release with AFpPCH still high for FILT_CYCLES+2 synchronised cycles, dac_code=1.
